mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single 16-bit-backed memory interface between the instruction-fetch unit and the load/store unit. The block accepts one request at a time from either requester with a req/ack handshake. It drives the interface's load/store strobes and holds its address and data stable. It waits for output_valid/write_ready, then returns read data to the winning requester. Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, consecutive data-port grants while fetch is pending before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 16, cycles in WAIT before abort (only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  one clock; reset is asynchronous and active-low
if_req  in  1  fetch request, held until if_ack
if_addr  in  12  fetch word address
if_ack  out  1  one-cycle completion pulse to fetch
if_rdata  out  32  fetch data, valid with if_ack
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  12  data address
ls_wdata  in  32  store data
ls_word_type  in  2  10 word, 01 halfword, 00 byte
ls_signed  in  1  sign-extend loads
ls_ack  out  1  one-cycle completion pulse to load/store unit
ls_rdata  out  32  load data, valid with ls_ack
ls_err  out  1  timeout abort flag, valid with ls_ack (tied 0 without the optional feature)
mi_address  out  12  to interface address
mi_data_in  out  32  to interface data_in
mi_load  out  1  to interface load
mi_store  out  1  to interface store
mi_is_signed  out  1  to interface is_signed
mi_word_type  out  2  to interface word_type
mi_data_out  in  32  from interface data_out
mi_output_valid  in  1  from interface, load complete
mi_write_ready  in  1  from interface, store complete
mi_busy  in  1  from interface, transaction in progress

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, starve counter 0, latched request registers 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if (if_req|ls_req) and !mi_busy, choose the winner.
  - ls wins unless if_req=1 and starve_cnt==STARVE_LIMIT.
  - Latch addr/wdata/we/word_type/signed from the winner. Fetch is always word, unsigned, load.
  - Go to ISSUE.
- Starve counter:
  - Increments on each ls grant while if_req=1.
  - Clears on any if grant, or when if_req=0 at an ls grant.
  - Saturates at STARVE_LIMIT.
- ISSUE (1 cycle): mi_load=!we or mi_store=we, driven for exactly this cycle. Go to WAIT.
- WAIT: hold load=store=0. Leave on mi_output_valid (load) or mi_write_ready (store).
  - Capture mi_data_out into the rdata register (stores capture 0). Go to DONE.
  - Completion in the same cycle as ISSUE exit is not possible; it is sampled only in WAIT.
- DONE (1 cycle): assert winner's ack=1; rdata is stable from this cycle until the next ack to the same port. Go to IDLE.
- mi_address/mi_data_in/mi_word_type/mi_is_signed: driven from the latch registers from ISSUE through DONE; unchanged in IDLE.
- Minimum transaction: 4 cycles from req sampled to ack (IDLE, ISSUE, WAIT≥1, DONE).
- Requester handshake:
  - req is sampled only in IDLE.
  - A req still high in the cycle after ack is treated as a new request.
  - Changing fields while req=1 before ack is illegal; the latched copy is used.
- Both req in the same IDLE cycle with mi_busy=1: no grant; re-evaluated each cycle.
- A reset assertion mid-transaction aborts immediately; no ack is issued for the aborted transaction.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A 5-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without completion, go to DONE with rdata=0, and ls_err=1 if ls owns the transaction.
  - A fetch timeout acks with if_rdata=0.
- Not defined: WAIT is unbounded and ls_err is constant 0.

Test Plan:
- Fetch only: if_req, if_addr=0x010, mi_output_valid with mi_data_out=0xDEADBEEF 2 cycles after mi_load -> if_ack one cycle later, if_rdata=0xDEADBEEF, mi_word_type=10.
- Store: ls_req, ls_we=1, ls_addr=0x7FE, ls_wdata=0x12345678, word -> single-cycle mi_store, mi_address=0x7FE held until ls_ack, ls_rdata=0.
- Simultaneous req, STARVE_LIMIT=4, ls_req held continuously -> grant order ls,ls,ls,ls,if,ls...
- mi_busy=1 in IDLE with both req -> no mi_load/mi_store until mi_busy=0.
- Reset pulled low during WAIT -> all outputs 0 asynchronously, no ack; after release, a new if_req completes normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ls load with no mi_output_valid -> ls_ack with ls_err=1, ls_rdata=0, 16 cycles after WAIT entry.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the
// shared memory interface. The arbiter takes the slave view; the environment takes master.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [11:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [11:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_word_type;
    logic        ls_signed;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic [11:0] mi_address;
    logic [31:0] mi_data_in;
    logic        mi_load;
    logic        mi_store;
    logic        mi_is_signed;
    logic [1:0]  mi_word_type;
    logic [31:0] mi_data_out;
    logic        mi_output_valid;
    logic        mi_write_ready;
    logic        mi_busy;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_word_type, ls_signed,
        input  mi_data_out, mi_output_valid, mi_write_ready, mi_busy,
        output if_ack, if_rdata, ls_ack, ls_rdata, ls_err,
        output mi_address, mi_data_in, mi_load, mi_store, mi_is_signed, mi_word_type
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_word_type, ls_signed,
        output mi_data_out, mi_output_valid, mi_write_ready, mi_busy,
        input  if_ack, if_rdata, ls_ack, ls_rdata, ls_err,
        input  mi_address, mi_data_in, mi_load, mi_store, mi_is_signed, mi_word_type
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory interface between fetch and load/store; data port wins,
// a starvation counter forces fetch through. Define MEM_ARB_TIMEOUT_EN for the WAIT timeout.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  word_type;
        logic        sgn;
        logic        own_ls;
    } req_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state, state_nxt;
    req_t        lat, lat_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [31:0] if_rdata_q, ls_rdata_q;
    logic        grant_ls;
    logic        cap;
    logic [31:0] cap_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);
    logic [4:0] to_cnt, to_nxt;
    logic       err_q, err_nxt;
`endif

    // fetch only beats the data port once it has watched STARVE_LIMIT ls grants go by
    assign grant_ls = bus.ls_req && !(bus.if_req && (starve_cnt == STARVE_MAX));

    always_comb begin
        state_nxt  = state;
        lat_nxt    = lat;
        starve_nxt = starve_cnt;
        cap        = 1'b0;
        cap_data   = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_nxt     = to_cnt;
        err_nxt    = err_q;
`endif
        unique case (state)
            IDLE: begin
                if ((bus.if_req || bus.ls_req) && !bus.mi_busy) begin
                    state_nxt = ISSUE;
                    if (grant_ls) begin
                        lat_nxt = '{addr: bus.ls_addr, wdata: bus.ls_wdata, we: bus.ls_we,
                                    word_type: bus.ls_word_type, sgn: bus.ls_signed,
                                    own_ls: 1'b1};
                        if (!bus.if_req)
                            starve_nxt = '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_nxt = starve_cnt + 4'd1;
                    end else begin
                        lat_nxt = '{addr: bus.if_addr, wdata: 32'd0, we: 1'b0,
                                    word_type: 2'b10, sgn: 1'b0, own_ls: 1'b0};
                        starve_nxt = '0;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                to_nxt  = '0;
                err_nxt = 1'b0;
`endif
            end
            WAIT: begin
                if (lat.we ? bus.mi_write_ready : bus.mi_output_valid) begin
                    state_nxt = DONE;
                    cap       = 1'b1;
                    cap_data  = lat.we ? 32'd0 : bus.mi_data_out;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_nxt = DONE;
                    cap       = 1'b1;
                    err_nxt   = lat.own_ls;
                end else begin
                    to_nxt = to_cnt + 5'd1;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat        <= '0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state      <= state_nxt;
            lat        <= lat_nxt;
            starve_cnt <= starve_nxt;
            if (cap && lat.own_ls)  ls_rdata_q <= cap_data;
            if (cap && !lat.own_ls) if_rdata_q <= cap_data;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= to_nxt;
            err_q  <= err_nxt;
        end
    end
    assign bus.ls_err = (state == DONE) && lat.own_ls && err_q;
`else
    assign bus.ls_err = 1'b0;
`endif

    assign bus.mi_load      = (state == ISSUE) && !lat.we;
    assign bus.mi_store     = (state == ISSUE) && lat.we;
    assign bus.mi_address   = lat.addr;
    assign bus.mi_data_in   = lat.wdata;
    assign bus.mi_word_type = lat.word_type;
    assign bus.mi_is_signed = lat.sgn;
    assign bus.if_ack       = (state == DONE) && !lat.own_ls;
    assign bus.ls_ack       = (state == DONE) && lat.own_ls;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.ls_rdata     = ls_rdata_q;
endmodule
